// File: rtl/branch_resolver.sv
// In-order branch resolution queue: records predictions, checks outcomes, drives predictor update and fetch redirect.
// Latency: resolve at edge N -> update/redirect pulse in cycle N+1; alloc at edge N is resolvable from cycle N+1.
// Backpressure: alloc_ready drops when the queue is full; a same-cycle resolve does not free a slot for that cycle.
module branch_resolver #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    input  logic [31:0]                alloc_pc,
    input  logic                       alloc_pred,
    input  logic [31:0]                alloc_target,
    output logic                       alloc_ready,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic [31:0]                resolve_target,
    output logic                       update_valid,
    output logic [31:0]                update_pc,
    output logic                       update_taken,
    output logic                       update_correct,
    output logic                       redirect_valid,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           mispredict_cnt,
    output logic                       resolve_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    entry_t             wr_entry;

    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic [OW-1:0]      count_q, count_d;

    logic               update_valid_q, update_valid_d;
    logic [31:0]        update_pc_q, update_pc_d;
    logic               update_taken_q, update_taken_d;
    logic               update_correct_q, update_correct_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   mispredict_cnt_q, mispredict_cnt_d;
    logic               resolve_err_q, resolve_err_d;

    logic               queue_empty;
    logic               do_resolve;
    logic               mispredict;
    logic               do_alloc;

    assign queue_empty = (count_q == '0);
    assign alloc_ready = (count_q != OW'(DEPTH));
    assign head        = mem_q[rptr_q];
    assign do_resolve  = resolve_valid && !queue_empty;
    assign mispredict  = do_resolve &&
                         ((resolve_taken != head.pred) ||
                          (resolve_taken && head.pred && (resolve_target != head.target)));
    // A mispredict flushes the queue, so the same-cycle allocate belongs to the wrong path.
    assign do_alloc    = alloc_valid && alloc_ready && !mispredict;

    always_comb begin
        wr_entry.pc     = alloc_pc;
        wr_entry.pred   = alloc_pred;
        wr_entry.target = alloc_target;
    end

    always_comb begin
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        count_d          = count_q;
        update_valid_d   = do_resolve;
        update_pc_d      = update_pc_q;
        update_taken_d   = update_taken_q;
        update_correct_d = update_correct_q;
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        resolve_err_d    = resolve_err_q | (resolve_valid && queue_empty);

        if (do_resolve) begin
            update_pc_d      = head.pc;
            update_taken_d   = resolve_taken;
            update_correct_d = !mispredict;
        end

        if (mispredict) begin
            rptr_d           = wptr_q;
            count_d          = '0;
            redirect_pc_d    = resolve_taken ? resolve_target : (head.pc + 32'd4);
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end else begin
            wptr_d  = wptr_q + PW'(do_alloc);
            rptr_d  = rptr_q + PW'(do_resolve);
            count_d = count_q + OW'(do_alloc) - OW'(do_resolve);
        end
    end

    // Entry storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            update_valid_q   <= 1'b0;
            update_pc_q      <= '0;
            update_taken_q   <= 1'b0;
            update_correct_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            mispredict_cnt_q <= '0;
            resolve_err_q    <= 1'b0;
        end else begin
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            count_q          <= count_d;
            update_valid_q   <= update_valid_d;
            update_pc_q      <= update_pc_d;
            update_taken_q   <= update_taken_d;
            update_correct_q <= update_correct_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            resolve_err_q    <= resolve_err_d;
        end
    end

    assign update_valid   = update_valid_q;
    assign update_pc      = update_pc_q;
    assign update_taken   = update_taken_q;
    assign update_correct = update_correct_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign occupancy      = count_q;
    assign mispredict_cnt = mispredict_cnt_q;
    assign resolve_err    = resolve_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed and random traffic against a queue-based model,
// expected per-cycle outputs scoreboarded and compared by an independent monitor.
module tb_branch_resolver;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic [31:0] alloc_target;
    logic        alloc_ready;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_correct;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  occupancy;
    logic [15:0] mispredict_cnt;
    logic        resolve_err;

    always #5 clk = ~clk;

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_valid    (alloc_valid),
        .alloc_pc       (alloc_pc),
        .alloc_pred     (alloc_pred),
        .alloc_target   (alloc_target),
        .alloc_ready    (alloc_ready),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_correct (update_correct),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy),
        .mispredict_cnt (mispredict_cnt),
        .resolve_err    (resolve_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        uc;
        logic        rv;
        logic [31:0] rpc;
        int          occ;
        logic        ready;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    ent_t mq[$];
    exp_t eq[$];

    logic [15:0] m_cnt;
    logic        m_err;
    logic [31:0] m_upc;
    logic        m_ut;
    logic        m_uc;
    logic [31:0] m_rpc;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // One clock of stimulus; the model advances by the queue rules and records what the next cycle must show.
    task automatic cyc(input bit av, input logic [31:0] apc, input bit apred, input logic [31:0] atgt,
                       input bit rv, input bit rt, input logic [31:0] rtgt, input bit rst);
        exp_t e;
        ent_t h;
        ent_t n;
        bit   ready;
        bit   ok;
        bit   mis;
        @(negedge clk);
        rst_n          = !rst;
        alloc_valid    = av;
        alloc_pc       = apc;
        alloc_pred     = apred;
        alloc_target   = atgt;
        resolve_valid  = rv;
        resolve_taken  = rt;
        resolve_target = rtgt;
        e.uv = 1'b0;
        e.rv = 1'b0;
        if (rst) begin
            mq.delete();
            m_cnt = '0; m_err = 1'b0; m_upc = '0; m_ut = 1'b0; m_uc = 1'b0; m_rpc = '0;
        end else begin
            ready = (mq.size() != DEPTH);
            mis   = 1'b0;
            if (rv && mq.size() == 0) begin
                m_err = 1'b1;
            end else if (rv) begin
                h  = mq.pop_front();
                ok = (rt == h.pred) && (!rt || rtgt == h.tgt);
                e.uv  = 1'b1;
                m_upc = h.pc;
                m_ut  = rt;
                m_uc  = ok;
                if (!ok) begin
                    mis   = 1'b1;
                    e.rv  = 1'b1;
                    m_rpc = rt ? rtgt : h.pc + 32'd4;
                    m_cnt = m_cnt + 16'd1;
                    mq.delete();
                end
            end
            if (av && ready && !mis) begin
                n.pc = apc; n.pred = apred; n.tgt = atgt;
                mq.push_back(n);
            end
        end
        e.upc   = m_upc;
        e.ut    = m_ut;
        e.uc    = m_uc;
        e.rpc   = m_rpc;
        e.occ   = mq.size();
        e.ready = (mq.size() != DEPTH);
        e.cnt   = m_cnt;
        e.err   = m_err;
        eq.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic alloc(input logic [31:0] pc, input bit pred, input logic [31:0] tgt);
        cyc(1, pc, pred, tgt, 0, 0, 32'h0, 0);
    endtask

    task automatic resolve(input bit rt, input logic [31:0] rtgt);
        cyc(0, 32'h0, 0, 32'h0, 1, rt, rtgt, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() > 0) begin
                e = eq.pop_front();
                chk("update_valid",   32'(update_valid),   32'(e.uv));
                chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                chk("update_pc",      update_pc,           e.upc);
                chk("update_taken",   32'(update_taken),   32'(e.ut));
                chk("update_correct", 32'(update_correct), 32'(e.uc));
                chk("redirect_pc",    redirect_pc,         e.rpc);
                chk("occupancy",      32'(occupancy),      32'(e.occ));
                chk("alloc_ready",    32'(alloc_ready),    32'(e.ready));
                chk("mispredict_cnt", 32'(mispredict_cnt), 32'(e.cnt));
                chk("resolve_err",    32'(resolve_err),    32'(e.err));
            end
        end
    end

    initial begin : driver
        logic [31:0] r;
        logic [31:0] pc;
        bit          rt;
        logic [31:0] rtgt;
        rst_n = 1'b0;
        alloc_valid = 0; alloc_pc = 0; alloc_pred = 0; alloc_target = 0;
        resolve_valid = 0; resolve_taken = 0; resolve_target = 0;

        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        alloc(32'h100, 1, 32'h200);
        resolve(1, 32'h200);
        idle();

        alloc(32'h40, 0, 32'h0);
        resolve(1, 32'h80);
        alloc(32'h40, 1, 32'h1000);
        resolve(0, 32'h0);
        alloc(32'hFFFF_FFFC, 1, 32'h8);
        resolve(0, 32'h0);

        for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + 32'(i * 4), 1, 32'h2000 + 32'(i * 4));
        cyc(1, 32'h3000, 1, 32'h0, 1, 1, 32'h2000, 0);
        for (int i = 1; i < DEPTH; i++) resolve(1, 32'h2000 + 32'(i * 4));
        idle();

        alloc(32'h500, 1, 32'h600);
        alloc(32'h504, 1, 32'h600);
        alloc(32'h508, 1, 32'h600);
        cyc(1, 32'h50C, 1, 32'h600, 1, 1, 32'h700, 0);
        resolve(1, 32'h600);
        idle();

        for (int i = 0; i < 5; i++) alloc(32'h700 + 32'(i * 4), 0, 32'h0);
        cyc(1, 32'h800, 1, 32'h900, 1, 1, 32'h1234, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        alloc(32'hA00, 0, 32'h0);
        resolve(0, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            r  = $urandom;
            pc = r & 32'hFFFF_FFFC;
            if (mq.size() > 0 && $urandom_range(0, 9) != 0) begin
                rt   = mq[0].pred;
                rtgt = mq[0].tgt;
            end else begin
                rt   = 1'($urandom_range(0, 1));
                rtgt = 32'h4000 + 32'($urandom_range(0, 3) * 4);
            end
            cyc(($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)),
                32'h4000 + 32'($urandom_range(0, 3) * 4),
                ($urandom_range(0, 2) == 0), rt, rtgt,
                ($urandom_range(0, 499) == 0));
        end

        idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drain", 32'(eq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
